// File: rtl/spm_rr_ctrl.sv
// Pipelined scratchpad controller: arbitrates NR_PORTS requesters onto NR_WAYS way SRAMs,
// one access per cycle, in-order read responses after a fixed RD_LATENCY.
module spm_rr_ctrl #(
  parameter int          NR_PORTS   = 3,
  parameter int          NR_WAYS    = 4,
  parameter int          LINE_WIDTH = 128,
  parameter int          DATA_WIDTH = 64,
  parameter int          TAG_WIDTH  = 44,
  parameter int          ADDR_WIDTH = 64,
  parameter int          IDX_WIDTH  = 12,
  parameter int          RD_LATENCY = 1,
  parameter int          RR_ARB     = 1,
  parameter logic [63:0] ERR_DATA   = 64'hCA11AB1E_BADCAB1E
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NR_WAYS-1:0]                            active_ways_i,
  input  logic [NR_PORTS-1:0]                           req_i,
  input  logic [NR_PORTS-1:0]                           we_i,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0]                addr_i,
  input  logic [NR_PORTS*DATA_WIDTH-1:0]                wdata_i,
  input  logic [NR_PORTS*DATA_WIDTH/8-1:0]              be_i,
  output logic [NR_PORTS-1:0]                           gnt_o,
  output logic [NR_PORTS-1:0]                           rvalid_o,
  output logic [NR_PORTS*DATA_WIDTH-1:0]                rdata_o,
  output logic [NR_PORTS-1:0]                           err_o,
  output logic [NR_WAYS-1:0]                            mem_req_o,
  output logic                                          mem_we_o,
  output logic [IDX_WIDTH-1:0]                          mem_addr_o,
  output logic [TAG_WIDTH+LINE_WIDTH-1:0]               mem_wdata_o,
  output logic [(TAG_WIDTH+LINE_WIDTH+7)/8-1:0]         mem_be_o,
  input  logic [NR_WAYS*(TAG_WIDTH+LINE_WIDTH)-1:0]     mem_rdata_i
);

  localparam int MW    = TAG_WIDTH + LINE_WIDTH;
  localparam int MBW   = (MW + 7) / 8;
  localparam int LBW   = LINE_WIDTH / 8;
  localparam int DBW   = DATA_WIDTH / 8;
  localparam int WORDS = LINE_WIDTH / DATA_WIDTH;
  localparam int OFF_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BOFF  = $clog2(DBW);
  localparam int WAY_W = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;
  localparam int PW    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int LAST  = RD_LATENCY - 1;
  localparam logic [DATA_WIDTH-1:0] ERR_W = ERR_DATA[DATA_WIDTH-1:0];

  logic [PW-1:0]            ptr_q;
  logic [PW-1:0]            win;
  logic                     any_req;
  logic                     grant;
  logic [ADDR_WIDTH-1:0]    g_addr;
  logic                     g_we;
  logic [DATA_WIDTH-1:0]    g_wdata;
  logic [DBW-1:0]           g_be;
  logic [WAY_W-1:0]         g_way;
  logic [OFF_W-1:0]         g_off;
  logic                     g_ok;
  logic [2**WAY_W-1:0]      act_ext;
  logic [2**WAY_W-1:0]      req_ext;

  // Read pipeline: one {valid, port, way, offset, err} entry per latency stage.
  logic [RD_LATENCY-1:0]    pv_q;
  logic [RD_LATENCY-1:0]    pe_q;
  logic [PW-1:0]            pp_q [RD_LATENCY];
  logic [WAY_W-1:0]         pw_q [RD_LATENCY];
  logic [OFF_W-1:0]         po_q [RD_LATENCY];

  // Scan downwards so the lowest rotated index is the last (winning) match.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int i = NR_PORTS - 1; i >= 0; i--) begin
      if (RR_ARB != 0) begin
        if (req_i[(int'(ptr_q) + i) % NR_PORTS]) begin
          win     = PW'((int'(ptr_q) + i) % NR_PORTS);
          any_req = 1'b1;
        end
      end else if (req_i[i]) begin
        win     = PW'(i);
        any_req = 1'b1;
      end
    end
  end

  assign grant   = any_req & rst_ni;
  assign g_addr  = addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
  assign g_we    = we_i[win];
  assign g_wdata = wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
  assign g_be    = be_i[int'(win)*DBW +: DBW];
  assign g_way   = g_addr[IDX_WIDTH +: WAY_W];
  assign g_off   = (WORDS > 1) ? g_addr[BOFF +: OFF_W] : '0;
  assign g_ok    = act_ext[g_way];

  // Way indices beyond NR_WAYS read as inactive.
  always_comb begin
    act_ext                = '0;
    act_ext[NR_WAYS-1:0]   = active_ways_i;
  end

  always_comb begin
    gnt_o       = '0;
    req_ext     = '0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (grant) begin
      gnt_o[win] = 1'b1;
      if (g_ok) begin
        req_ext[g_way] = 1'b1;
        mem_we_o       = g_we;
        mem_addr_o     = g_addr[IDX_WIDTH-1:0];
        if (g_we) begin
          mem_wdata_o[int'(g_off)*DATA_WIDTH +: DATA_WIDTH] = g_wdata;
          mem_be_o[int'(g_off)*DBW +: DBW]                  = g_be;
          for (int b = LBW; b < MBW; b++) mem_be_o[b] = 1'b1;
        end
      end
    end
    mem_req_o = req_ext[NR_WAYS-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      pv_q  <= '0;
      pe_q  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pp_q[i] <= '0;
        pw_q[i] <= '0;
        po_q[i] <= '0;
      end
    end else begin
      if (grant && RR_ARB != 0)
        ptr_q <= (int'(win) == NR_PORTS - 1) ? '0 : win + PW'(1);
      pv_q[0] <= grant & ~g_we;
      pe_q[0] <= ~g_ok;
      pp_q[0] <= win;
      pw_q[0] <= g_way;
      po_q[0] <= g_off;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pp_q[i] <= pp_q[i-1];
        pw_q[i] <= pw_q[i-1];
        po_q[i] <= po_q[i-1];
      end
    end
  end

  // Write errors flag at grant; read errors flag with their response.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    err_o    = '0;
    if (grant && g_we && !g_ok) err_o[win] = 1'b1;
    if (pv_q[LAST]) begin
      rvalid_o[pp_q[LAST]] = 1'b1;
      if (pe_q[LAST]) begin
        err_o[pp_q[LAST]] = 1'b1;
        rdata_o[int'(pp_q[LAST])*DATA_WIDTH +: DATA_WIDTH] = ERR_W;
      end else begin
        rdata_o[int'(pp_q[LAST])*DATA_WIDTH +: DATA_WIDTH] =
          mem_rdata_i[int'(pw_q[LAST])*MW + int'(po_q[LAST])*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: doc/spm_rr_ctrl.md
Name: spm_rr_ctrl

Overview:
Pipelined scratchpad (SPM) controller. It arbitrates NR_PORTS requesters onto NR_WAYS data-cache way memories running in SPM mode. It issues at most one access per cycle and returns read data after a fixed, parametrised latency, so multiple reads can be in flight. It sits between the SPM request splitter/ports and the way SRAMs, and generalises the single-outstanding, fixed-priority SPM controller with round-robin arbitration, configurable word width and an in-order error path.

Parameters:
NR_PORTS, 3, number of requester ports (>=1)
NR_WAYS, 4, number of way memories (>=1, power of two not required)
LINE_WIDTH, 128, data bits per memory line
DATA_WIDTH, 64, port word width (power of two, <= LINE_WIDTH)
TAG_WIDTH, 44, tag bits stored above the line; always zeroed on writes
ADDR_WIDTH, 64, port address width
IDX_WIDTH, 12, index plus byte-offset bits forwarded to the memories
RD_LATENCY, 1, cycles from memory request to rdata_i valid (>=1)
RR_ARB, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
ERR_DATA, 64'hCA11AB1E_BADCAB1E, read data returned for disabled/nonexistent ways (truncated to DATA_WIDTH)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
active_ways_i  in  NR_WAYS  1 = way is usable as SPM
req_i  in  NR_PORTS  request valid per port
we_i  in  NR_PORTS  1 = write
addr_i  in  NR_PORTS*ADDR_WIDTH  byte address
wdata_i  in  NR_PORTS*DATA_WIDTH  write data
be_i  in  NR_PORTS*DATA_WIDTH/8  write byte enables
gnt_o  out  NR_PORTS  request accepted this cycle
rvalid_o  out  NR_PORTS  read response valid
rdata_o  out  NR_PORTS*DATA_WIDTH  read response data
err_o  out  NR_PORTS  response targets an inactive or nonexistent way (qualified by rvalid_o or gnt_o)
mem_req_o  out  NR_WAYS  one-hot way enable
mem_we_o  out  1  write enable
mem_addr_o  out  IDX_WIDTH  line address
mem_wdata_o  out  TAG_WIDTH+LINE_WIDTH  {tag zeros, line}
mem_be_o  out  (TAG_WIDTH+LINE_WIDTH+7)/8  byte enables
mem_rdata_i  in  NR_WAYS*(TAG_WIDTH+LINE_WIDTH)  way read data

Behaviour:
- Reset: every output is 0, the RR pointer is 0 and the pipeline valid bits are 0. Reset asserted mid-flight drops all in-flight reads; no rvalid follows.
- Decode per port:
  - word offset = addr[$clog2(LINE_WIDTH/8)-1 : $clog2(DATA_WIDTH/8)]
  - way = addr[IDX_WIDTH +: max(1,$clog2(NR_WAYS))]
  - mem_addr_o = addr[IDX_WIDTH-1:0]
- Arbitration (combinational, one winner per cycle):
  - RR_ARB=1: the winner is the first requesting port at or after the pointer, with wrap-around. After any grant, the pointer becomes winner+1 mod NR_PORTS.
  - RR_ARB=0: the lowest requesting index wins.
- Grant: gnt_o[winner]=1 in the same cycle for reads and writes. There is no backpressure; throughput is one access per cycle. Losers hold req_i until granted.
- Valid access (way < NR_WAYS and active_ways_i[way]=1):
  - mem_req_o[way]=1 and mem_we_o=we.
  - Write: mem_wdata_o = {TAG_WIDTH'0, wdata placed at offset*DATA_WIDTH}. mem_be_o = be_i at offset*(DATA_WIDTH/8), plus all tag bytes = 1. All other be bits = 0.
  - Read: mem_be_o = 0.
- Invalid way: no mem_req_o. A write gets gnt_o with err_o=1 in the same cycle. A read is granted and still enters the pipeline, marked err.
- Read pipeline: a shift register of RD_LATENCY stages, each holding {valid, port, way, offset, err}.
  - Stage RD_LATENCY-1 drives rvalid_o[port]=1 exactly RD_LATENCY cycles after the grant.
  - rdata_o = mem_rdata_i[way][offset*DATA_WIDTH +: DATA_WIDTH], or ERR_DATA with err_o=1 when err.
  - Responses stay in grant order. Back-to-back reads return on consecutive cycles.
- Writes produce no rvalid. A read response and a new grant on the same port in the same cycle are both legal.
- rdata_o for a port is 0 when that port's rvalid_o=0.
- active_ways_i is sampled at grant time. Later changes do not affect requests already in flight.

Test Plan:
- Single read, RD_LATENCY=1: port 0 reads addr 0x1008, way 1 active, mem_rdata_i[1] line = {64'hAAAA, 64'h5555} -> gnt_o[0] at cycle 0, rvalid_o[0] at cycle 1 with rdata=64'hAAAA.
- Write: port 1 writes addr 0x0000 (way 0), wdata=64'h1234, be=8'h0F -> mem_req_o=4'b0001, mem_we_o=1, mem_be_o low 16 bits=16'h000F, all tag bytes=1, tag data=0.
- Round-robin fairness: all 3 ports request reads every cycle with RR_ARB=1 -> grants rotate 0,1,2,0,… and each port gets 1 grant per 3 cycles. With RR_ARB=0, only port 0 is granted.
- Pipelining, RD_LATENCY=3: 4 back-to-back reads from ports 2,0,1,2 -> rvalid on cycles 3,4,5,6 in that port order with matching data.
- Disabled way: active_ways_i=4'b1101, read to way 1 -> no mem_req_o; rvalid after RD_LATENCY with rdata=64'hCA11AB1E_BADCAB1E and err_o=1. A write to the same way gets gnt_o=1 and err_o=1 in the same cycle.
- Reset mid-flight: assert rst_ni=0 with 2 reads in flight (RD_LATENCY=3) -> no rvalid_o afterwards, all outputs 0, and the first grant after reset goes to port 0.
